// File: rtl/fetch_stage_ifid_if.sv
// Instruction memory request/response bundle between the fetch stage and imem.
interface fetch_stage_ifid_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_ifid.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// One outstanding imem request; stale responses after a redirect are dropped in StKill.
module fetch_stage_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      PCWrite,
  input  logic                      IF_ID_Write,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  fetch_stage_ifid_if.master        imem,
  output logic [31:0]               IF_ID_PC,
  output logic [31:0]               IF_ID_Instr,
  output logic                      IF_ID_Valid
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_inc;
  logic [31:0] ifid_pc_d, ifid_instr_d;
  logic        ifid_valid_d;
  logic        advance;
  logic        req;
  logic        unused_target_lsbs;

  assign advance            = PCWrite & IF_ID_Write;
  assign pc_inc             = pc_q + 32'd4;
  assign unused_target_lsbs = ^branch_target[1:0];

  // No request may leave the stage while reset is held.
  assign imem.imem_req = req & rst_n;

  // Next-state, PC, IF/ID and request generation.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    ifid_pc_d      = IF_ID_PC;
    ifid_instr_d   = IF_ID_Instr;
    ifid_valid_d   = IF_ID_Valid;
    req            = 1'b0;
    imem.imem_addr = pc_q;

    // Nothing delivered: a writable IF/ID takes a bubble, keeping its PC.
    if (IF_ID_Write) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end

    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      unique case (state_q)
        StFetch: state_d = imem.imem_gnt ? StKill : StFetch;
        StWait:  state_d = imem.imem_rvalid ? StFetch : StKill;
        StHold:  state_d = StFetch;
        StKill:  state_d = imem.imem_rvalid ? StFetch : StKill;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          req = 1'b1;
          if (imem.imem_gnt) state_d = StWait;
        end
        StWait: begin
          if (imem.imem_rvalid) begin
            if (advance) begin
              ifid_pc_d      = pc_q;
              ifid_instr_d   = imem.imem_rdata;
              ifid_valid_d   = 1'b1;
              pc_d           = pc_inc;
              // Back-to-back request keeps zero-wait memory at one instruction per cycle.
              req            = 1'b1;
              imem.imem_addr = pc_inc;
              state_d        = imem.imem_gnt ? StWait : StFetch;
            end else begin
              buf_d   = imem.imem_rdata;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = buf_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
            state_d      = StFetch;
          end
        end
        StKill: begin
          if (imem.imem_rvalid) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State, PC, buffer and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      buf_q       <= NOP_INSTR;
      IF_ID_PC    <= 32'h0000_0000;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      IF_ID_PC    <= ifid_pc_d;
      IF_ID_Instr <= ifid_instr_d;
      IF_ID_Valid <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ifid.sv
// Directed bench for fetch_stage_ifid with a small variable-latency imem model.
module tb_fetch_stage_ifid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, IF_ID_Write, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] IF_ID_PC, IF_ID_Instr;
  logic        IF_ID_Valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // imem model state
  logic        gnt_en = 1'b1;
  int unsigned lat = 1;
  int unsigned wait_cnt = 0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] pend_addr = 32'h0;

  fetch_stage_ifid_if bus ();

  assign bus.imem_gnt    = gnt_en & bus.imem_req;
  assign bus.imem_rvalid = mem_rvalid;
  assign bus.imem_rdata  = mem_rdata;

  fetch_stage_ifid dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus.master),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_Valid   (IF_ID_Valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // One response per grant, delivered `lat` cycles after the granting edge.
  always @(posedge clk) begin
    if (mem_rvalid) mem_rvalid <= 1'b0;
    if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
      if (wait_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= instr_of(pend_addr);
      end
    end
    if (bus.imem_req && bus.imem_gnt) begin
      pend_addr <= bus.imem_addr;
      if (lat == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= instr_of(bus.imem_addr);
      end else begin
        wait_cnt <= lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    // Reset state
    step(); step();
    chk("rst_valid", {31'b0, IF_ID_Valid}, 32'd0);
    chk("rst_instr", IF_ID_Instr, 32'h0000_0013);
    chk("rst_pc", IF_ID_PC, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    rst_n = 1'b1; #1;
    chk("t1_req0", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h0);

    // Zero-wait streaming
    step(); #1;
    chk("t1_addr4", bus.imem_addr, 32'h4);
    chk("t1_valid_e1", {31'b0, IF_ID_Valid}, 32'd0);
    step(); #1;
    chk("t1_pc0", IF_ID_PC, 32'h0);
    chk("t1_instr0", IF_ID_Instr, instr_of(32'h0));
    chk("t1_v0", {31'b0, IF_ID_Valid}, 32'd1);
    chk("t1_addr8", bus.imem_addr, 32'h8);
    step();
    chk("t1_pc4", IF_ID_PC, 32'h4);
    chk("t1_instr4", IF_ID_Instr, instr_of(32'h4));

    // Stall for three cycles while the 0x8 response arrives
    PCWrite = 1'b0; IF_ID_Write = 1'b0; #1;
    chk("t2_noreq_a", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t2_hold_pc_a", IF_ID_PC, 32'h4);
    chk("t2_hold_v_a", {31'b0, IF_ID_Valid}, 32'd1);
    chk("t2_noreq_b", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t2_hold_pc_b", IF_ID_PC, 32'h4);
    chk("t2_noreq_c", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t2_hold_pc_c", IF_ID_PC, 32'h4);
    PCWrite = 1'b1; IF_ID_Write = 1'b1; #1;
    chk("t2_noreq_rel", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t2_pc8", IF_ID_PC, 32'h8);
    chk("t2_instr8", IF_ID_Instr, instr_of(32'h8));
    chk("t2_v8", {31'b0, IF_ID_Valid}, 32'd1);
    chk("t2_addrc", bus.imem_addr, 32'hC);
    lat = 3;

    // Redirect to 0x103 while waiting on a 3-cycle response
    step();
    chk("t3_bubble_v", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t3_bubble_pc", IF_ID_PC, 32'h8);
    branch_taken = 1'b1; branch_target = 32'h0000_0103; #1;
    chk("t3_br_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    branch_taken = 1'b0; #1;
    chk("t3_kill_v", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t3_kill_noreq_a", {31'b0, bus.imem_req}, 32'd0);
    step(); #1;
    chk("t3_kill_noreq_b", {31'b0, bus.imem_req}, 32'd0);
    step(); #1;
    chk("t3_stale_v", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t3_req100", {31'b0, bus.imem_req}, 32'd1);
    chk("t3_addr100", bus.imem_addr, 32'h100);
    step();
    chk("t3_wait_v_a", {31'b0, IF_ID_Valid}, 32'd0);
    step();
    chk("t3_wait_v_b", {31'b0, IF_ID_Valid}, 32'd0);
    step();
    chk("t3_wait_v_c", {31'b0, IF_ID_Valid}, 32'd0);
    step();
    chk("t3_pc100", IF_ID_PC, 32'h100);
    chk("t3_instr100", IF_ID_Instr, instr_of(32'h100));
    chk("t3_v100", {31'b0, IF_ID_Valid}, 32'd1);

    // Redirect while IF/ID is stalled still flushes it
    IF_ID_Write = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0200; #1;
    chk("t4_br_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t4_instr_nop", IF_ID_Instr, 32'h0000_0013);
    chk("t4_v0", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t4_pc_keep", IF_ID_PC, 32'h100);
    branch_taken = 1'b0; IF_ID_Write = 1'b1; #1;
    chk("t4_kill_noreq_a", {31'b0, bus.imem_req}, 32'd0);
    step(); #1;
    chk("t4_kill_noreq_b", {31'b0, bus.imem_req}, 32'd0);
    step();
    lat = 1; #1;
    chk("t4_req200", {31'b0, bus.imem_req}, 32'd1);
    chk("t4_addr200", bus.imem_addr, 32'h200);
    step();
    lat = 3; #1;
    chk("t4_addr204", bus.imem_addr, 32'h204);
    step();
    chk("t4_pc200", IF_ID_PC, 32'h200);
    chk("t4_instr200", IF_ID_Instr, instr_of(32'h200));

    // Reset while a request is outstanding
    rst_n = 1'b0; #1;
    chk("t5_rst_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("t5_rst_v", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t5_rst_pc", IF_ID_PC, 32'h0);
    chk("t5_rst_instr", IF_ID_Instr, 32'h0000_0013);
    step();
    rst_n = 1'b1; lat = 1; #1;
    chk("t5_req0", {31'b0, bus.imem_req}, 32'd1);
    chk("t5_addr0", bus.imem_addr, 32'h0);
    step(); #1;
    chk("t5_late_ignored", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t5_addr4", bus.imem_addr, 32'h4);
    step();
    chk("t5_pc0", IF_ID_PC, 32'h0);
    chk("t5_instr0", IF_ID_Instr, instr_of(32'h0));

    // Redirect to the top word and wrap around
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
    chk("t6_br_noreq", {31'b0, bus.imem_req}, 32'd0);
    step();
    branch_taken = 1'b0; #1;
    chk("t6_v0", {31'b0, IF_ID_Valid}, 32'd0);
    chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    step(); #1;
    chk("t6_addr_wrap", bus.imem_addr, 32'h0);
    step(); #1;
    chk("t6_pc_top", IF_ID_PC, 32'hFFFF_FFFC);
    chk("t6_instr_top", IF_ID_Instr, instr_of(32'hFFFF_FFFC));
    chk("t6_addr4", bus.imem_addr, 32'h4);
    step();
    chk("t6_pc_wrap", IF_ID_PC, 32'h0);
    chk("t6_v_wrap", {31'b0, IF_ID_Valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
